// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_br;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             w_last;
    logic             w_d;
    logic             w_br_next;

    assign w_last    = (r_cnt == LAST);
    assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_next = SHIFT;
            SHIFT:   if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_br   <= 1'b0;
            r_diff <= '0;
            r_bout <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_cnt <= '0;
            r_a   <= a;
            r_b   <= b;
            r_br  <= bin;
        end else if (r_state == SHIFT) begin
            // Result enters at the MSB so that after WIDTH shifts bit 0 is the LSB.
            r_cnt  <= r_cnt + CW'(1);
            r_a    <= {1'b0, r_a[WIDTH-1:1]};
            r_b    <= {1'b0, r_b[WIDTH-1:1]};
            r_br   <= w_br_next;
            r_diff <= {w_d, r_diff[WIDTH-1:1]};
            if (w_last) r_bout <= w_br_next;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic r_sa;
    logic r_sb;
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa  <= 1'b0;
            r_sb  <= 1'b0;
            r_ovf <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_sa <= a[WIDTH-1];
            r_sb <= b[WIDTH-1];
        end else if (r_state == SHIFT && w_last) begin
            r_ovf <= (r_sa ^ r_sb) & (r_sa ^ w_d);
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy = (r_state == SHIFT);
    assign done = (r_state == DONE);
    assign diff = r_diff;
    assign bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
// Define SERIAL_SUB_OVF_EN for both files to exercise the overflow flag.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One operation from IDLE; optionally pulses start with a=FF at busy sample glitch_at.
    task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic ibin, input int glitch_at,
                          input logic [W-1:0] ed, input logic eb);
        int n;
        @(negedge clk);
        a = ia; b = ib; bin = ibin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            if (busy) n++;
            if (n == glitch_at) begin
                start = 1'b1; a = 8'hFF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_busy_cycles"}, n, 8);
        check({tag, "_done"}, done, 1);
        check({tag, "_diff"}, diff, ed);
        check({tag, "_bout"}, bout, eb);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_diff_hold"}, diff, ed);
    endtask

    initial begin
        int done_cnt;
        int last_done;
        int seen_done;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        run_op("sub_0F_05", 8'h0F, 8'h05, 1'b0, -1, 8'h0A, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
        check("ovf_0F_05", ovf, 0);
`endif
        run_op("sub_05_0F", 8'h05, 8'h0F, 1'b0, -1, 8'hF6, 1'b1);
        run_op("sub_00_00_bin", 8'h00, 8'h00, 1'b1, -1, 8'hFF, 1'b1);
        run_op("restart_ignored", 8'h0F, 8'h05, 1'b0, 3, 8'h0A, 1'b0);

        // Abort mid-operation via asynchronous reset.
        @(negedge clk);
        a = 8'h0F; b = 8'h05; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_diff", diff, 0);
        check("abort_bout", bout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        check("abort_no_done", seen_done, 0);
        run_op("after_abort", 8'h0F, 8'h05, 1'b0, -1, 8'h0A, 1'b0);

        // Start held high: back-to-back operations every WIDTH+2 cycles.
        @(negedge clk);
        a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
        done_cnt = 0; last_done = -1;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            if (done) begin
                check("held_diff", diff, 8'h0F);
                check("held_bout", bout, 0);
                if (last_done >= 0) check("held_spacing", c - last_done, 10);
                last_done = c;
                done_cnt++;
            end
        end
        check("held_done_count", done_cnt, 3);
        start = 1'b0;
        repeat (12) @(negedge clk);

`ifdef SERIAL_SUB_OVF_EN
        run_op("ovf_80_01", 8'h80, 8'h01, 1'b0, -1, 8'h7F, 1'b0);
        check("ovf_80_01_ovf", ovf, 1);
        run_op("ovf_7F_FF", 8'h7F, 8'hFF, 1'b0, -1, 8'h80, 1'b1);
        check("ovf_7F_FF_ovf", ovf, 1);
        run_op("ovf_05_03", 8'h05, 8'h03, 1'b0, -1, 8'h02, 1'b0);
        check("ovf_05_03_ovf", ovf, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
